// File: rtl/exec_mulx_seq.sv
`default_nettype none
// ============================================================================
// exec_mulx_seq : radix-2 shift-add multiplier, low W_OPR bits + {ovf,sign,zero,carry}
// Optional: MULX_EARLY_EXIT_EN ends RUN as soon as the remaining multiplier is 0.
// Revision: 1.0
// ============================================================================
module exec_mulx_seq #(
  parameter int W_OPR   = 32,
  parameter int W_FLAGS = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [W_OPR-1:0]   opr0_i,
  input  logic [W_OPR-1:0]   opr1_i,
  output logic               busy_o,
  output logic               valid_o,
  output logic [W_OPR-1:0]   result_o,
  output logic [W_FLAGS-1:0] flags_o
);

  localparam int W_CNT = $clog2(W_OPR + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [2*W_OPR-1:0]     mcand_q, mcand_d;
  logic [2*W_OPR-1:0]     acc_q, acc_d;
  logic [W_OPR-1:0]       mplier_q, mplier_d;
  logic [W_CNT-1:0]       cnt_q, cnt_d;
  logic                   sign_q, sign_d;
  logic [W_OPR-1:0]       result_q, result_d;
  logic [W_FLAGS-1:0]     flags_q, flags_d;

  logic [2*W_OPR-1:0]     acc_step;
  logic [W_OPR-1:0]       mplier_step;
  logic [W_CNT-1:0]       cnt_step;
  logic                   last_step;

  // One iteration of the shift-add recurrence; mcand_q is pre-shifted to the current bit.
  always_comb begin
    acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);
    mplier_step = mplier_q >> 1;
    cnt_step    = cnt_q - W_CNT'(1);
`ifdef MULX_EARLY_EXIT_EN
    last_step   = (cnt_step == '0) || (mplier_step == '0);
`else
    last_step   = (cnt_step == '0);
`endif
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          mcand_d  = {{W_OPR{1'b0}}, opr0_i};
          mplier_d = opr1_i;
          acc_d    = '0;
          cnt_d    = W_CNT'(W_OPR);
          sign_d   = opr0_i[W_OPR-1] ^ opr1_i[W_OPR-1];
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_step;
        cnt_d    = cnt_step;
        if (last_step) begin
          state_d  = ST_DONE;
          result_d = acc_step[W_OPR-1:0];
          flags_d  = {sign_q ^ acc_step[W_OPR-1],
                      sign_q,
                      ~|acc_step[W_OPR-1:0],
                      |acc_step[2*W_OPR-1:W_OPR]};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign busy_o   = (state_q == ST_RUN);
  assign valid_o  = (state_q == ST_DONE);
  assign result_o = result_q;
  assign flags_o  = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_mulx_seq.sv
`default_nettype none
// Scoreboard bench for exec_mulx_seq: directed operands, queue of expected
// {result, flags, completion cycle}, monitor pops on every valid_o.
module tb_exec_mulx_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] opr0;
  logic [31:0] opr1;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic [3:0]  flags;

  exec_mulx_seq #(.W_OPR(32), .W_FLAGS(4)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .start_i  (start),
    .opr0_i   (opr0),
    .opr1_i   (opr1),
    .busy_o   (busy),
    .valid_o  (valid),
    .result_o (result),
    .flags_o  (flags)
  );

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int run_cycles(input logic [31:0] b);
    int n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
`ifndef MULX_EARLY_EXIT_EN
    n = 32;
`endif
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every valid_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result %h flags %b with nothing outstanding (cycle %0d)",
                 result, flags, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", result, e.r);
        check("flags", {28'd0, flags}, {28'd0, e.f});
        check("valid_cycle", cyc, e.c);
      end
    end
  end

  // Call right after a negedge: start is sampled at the next posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input bit push);
    exp_t e;
    start = 1'b1;
    opr0  = a;
    opr1  = b;
    if (push) begin
      e.r = er;
      e.f = ef;
      e.c = cyc + 1 + run_cycles(b);
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    opr0  = 32'hDEAD_BEEF;
    opr1  = 32'hCAFE_F00D;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    opr0  = '0;
    opr1  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic, plus busy duration
    issue(32'd7, 32'd6, 32'd42, 4'b0000, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, run_cycles(32'd6));
    drain();

    issue(32'h0001_0000, 32'h0001_0000, 32'h0,          4'b0011, 1'b1); drain();
    issue(32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE,  4'b0101, 1'b1); drain();
    issue(32'h4000_0000, 32'd2,         32'h8000_0000,  4'b1000, 1'b1); drain();
    issue(32'd0,         32'd5,         32'd0,          4'b0010, 1'b1); drain();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001,  4'b0001, 1'b1); drain();
    issue(32'd9,         32'd1,         32'd9,          4'b0000, 1'b1); drain();
    issue(32'd9,         32'h8000_0000, 32'h8000_0000,  4'b0101, 1'b1); drain();

    // start held with new operands while busy: ignored
    issue(32'd100, 32'h8000_0001, 32'h0000_0064, 4'b1101, 1'b1);
    start = 1'b1;
    opr0  = 32'd5;
    opr1  = 32'd5;
    repeat (10) @(negedge clk);
    start = 1'b0;
    drain();

    // Back-to-back: start during the DONE cycle
    issue(32'd11, 32'd13, 32'd143, 4'b0000, 1'b1);
    n = 0;
    while (valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_saw_done", {31'd0, valid}, 32'd1);
    issue(32'd3, 32'd5, 32'd15, 4'b0000, 1'b1);
    drain();

    // Reset in cycle 10 of RUN discards the operation
    issue(32'h0001_2345, 32'h8000_0000, 32'h0, 4'b0000, 1'b0);
    repeat (8) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_flags", {28'd0, flags}, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exec_mulx_seq.md
Name: exec_mulx_seq

Overview:
- Multi-cycle radix-2 shift-add multiplier execution unit. It is the inverse arithmetic companion to the combinational divide unit.
- Sits in the execute stage beside the other exec units.
- Accepts two W_OPR operands on a start pulse and returns the low W_OPR bits of the unsigned product.
- Flags use the same {overflow, sign, zero, carry} packing as the divide unit, so the flag-writeback path is shared.

Parameters:
W_OPR, 32, operand and result width (must be >= 2)
W_FLAGS, 4, flag vector width (fixed packing {overflow, sign, zero, carry})

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_n_i  input  1  reset, synchronous, active-low
start_i  input  1  request; sampled only when busy_o=0
opr0_i  input  W_OPR  multiplicand; latched at accepted start
opr1_i  input  W_OPR  multiplier; latched at accepted start
busy_o  output  1  high while an operation is in progress
valid_o  output  1  one-cycle pulse: result_o/flags_o updated this cycle
result_o  output  W_OPR  low W_OPR bits of opr0*opr1; held until next completion
flags_o  output  W_FLAGS  {overflow, sign, zero, carry}; held with result_o

Behaviour:
- Reset:
  - If rst_n_i=0 at an edge: state=IDLE; busy_o=0, valid_o=0, result_o=0, flags_o=0, iteration counter=0.
  - An operation in flight is discarded with no valid_o.
- States: IDLE, RUN, DONE.
  - IDLE: start_i=1 latches operands into internal regs (mcand, mplier, 2*W_OPR-bit accumulator=0, counter=W_OPR) and goes to RUN. Otherwise stays in IDLE.
  - RUN: busy_o=1. Each edge: if mplier[0], accumulator += mcand shifted to current bit position; mplier >>= 1; counter -= 1. When counter reaches 0, go to DONE.
  - DONE: valid_o=1 and busy_o=0 for exactly one cycle. result_o/flags_o are registered on the edge entering DONE. DONE behaves like IDLE for start_i (back-to-back accept). Without start_i it returns to IDLE.
- Latency:
  - start_i sampled at edge 0.
  - busy_o is high for cycles 1..W_OPR.
  - valid_o is high in cycle W_OPR+1.
  - Throughput is one op per W_OPR+1 cycles.
- start_i while busy_o=1 is ignored and not queued. Operand inputs changing after acceptance have no effect.
- Flag rules (P = full 2*W_OPR product, R = P[W_OPR-1:0]):
  - carry = |P[2*W_OPR-1:W_OPR], i.e. unsigned product overflow.
  - zero = (R == 0).
  - sign = opr0[W_OPR-1] ^ opr1[W_OPR-1], taken from the latched operands.
  - overflow = sign ^ R[W_OPR-1].
- Zero operand: runs the full iteration count (baseline). Result 0, zero=1.
- result_o/flags_o change only on the edge into DONE or on reset. They are stable between completions.

Optional Feature:
- Macro: MULX_EARLY_EXIT_EN.
- When defined: in RUN, if mplier after the shift of the current edge is 0, go to DONE immediately regardless of counter. Latency becomes (index of highest set bit of opr1)+1 RUN cycles, with a minimum of 1. opr1=0 or opr1=1 therefore completes with valid_o in cycle 2.
- When undefined: fixed W_OPR RUN cycles for all operands.
- Result and flags are identical in both builds.

Test Plan:
- Basic: opr0=7, opr1=6, start pulse -> busy_o high cycles 1..32, valid_o in cycle 33, result_o=42, flags_o=4'b0000.
- Carry/zero: opr0=0x00010000, opr1=0x00010000 -> result_o=0, flags_o=4'b0011 (zero=1, carry=1).
- Sign: opr0=0xFFFFFFFF, opr1=2 -> result_o=0xFFFFFFFE, flags_o=4'b0101 (sign=1, carry=1, overflow=0).
- Busy/back-to-back:
  - start_i held high with new operands during RUN -> ignored; first result unchanged.
  - start in the DONE cycle with 3*5 -> accepted; second valid_o exactly 33 cycles later with result 15.
- Reset mid-op: rst_n_i=0 in cycle 10 of RUN -> next cycle busy_o=0, result_o=0, flags_o=0. No valid_o pulse for 40 cycles without start.
- Early exit (MULX_EARLY_EXIT_EN defined): opr0=9, opr1=1 -> valid_o in cycle 2, result 9. opr1=0x80000000 still takes 32 RUN cycles.
